hyperbus_delay_ctrl: RTL and testbench



---
 rtl/hyperbus_delay_pkg.sv | 21 ++
 rtl/hyperbus_delay_ctrl.sv | 124 ++++++++++++
 tb/tb_hyperbus_delay_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hyperbus_delay_pkg.sv
// Shared types and helpers for the HyperBus RWDS delay-line control stage.
package hyperbus_delay_pkg;

  localparam int DELAY_WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_QUIET,
    STEP,
    SETTLE
  } delay_ctrl_state_e;

  // Clamp a raw 32-bit request to the highest tap a tapW-bit field can hold.
  function automatic logic [DELAY_WORD_W-1:0] sat_tap(input logic [DELAY_WORD_W-1:0] req,
                                                      input int unsigned tapW);
    logic [DELAY_WORD_W-1:0] maxTap;
    maxTap = (DELAY_WORD_W'(1) << tapW) - DELAY_WORD_W'(1);
    return (req > maxTap) ? maxTap : req;
  endfunction

endpackage

// File: rtl/hyperbus_delay_ctrl.sv
// Drives the RWDS delay-line tap select, walking one tap at a time toward the
// requested value and only while the PHY has been quiet long enough.
module hyperbus_delay_ctrl
  import hyperbus_delay_pkg::*;
#(
  parameter int TAP_W         = 3,
  parameter int QUIET_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int RESET_TAP     = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [DELAY_WORD_W-1:0] cfg_delay_i,
  input  logic                    cfg_valid_i,
  output logic                    cfg_ready_o,
  input  logic                    phy_busy_i,
  output logic [DELAY_WORD_W-1:0] delay_o,
  output logic                    busy_o,
  output logic [TAP_W-1:0]        tap_cur_o
);

  localparam int QW = $clog2(QUIET_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [TAP_W-1:0] RESET_TAP_V = TAP_W'(RESET_TAP);
  localparam logic [QW-1:0]    QLAST       = QW'(QUIET_CYCLES - 1);
  localparam logic [SW-1:0]    SLAST       = SW'(SETTLE_CYCLES - 1);

  delay_ctrl_state_e state_q, state_d;
  logic [TAP_W-1:0]  tap_q, tap_d;
  logic [TAP_W-1:0]  target_q, target_d;
  logic [QW-1:0]     qcnt_q, qcnt_d;
  logic [SW-1:0]     scnt_q, scnt_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;
  logic [TAP_W-1:0]  satTarget;

  assign satTarget = TAP_W'(sat_tap(cfg_delay_i, TAP_W));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      tap_q    <= RESET_TAP_V;
      target_q <= RESET_TAP_V;
      qcnt_q   <= '0;
      scnt_q   <= '0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      tap_q    <= tap_d;
      target_q <= target_d;
      qcnt_q   <= qcnt_d;
      scnt_q   <= scnt_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
    end
  end

  // A request equal to the applied tap is consumed without leaving IDLE.
  always_comb begin
    state_d  = state_q;
    tap_d    = tap_q;
    target_d = target_q;
    qcnt_d   = qcnt_q;
    scnt_d   = scnt_q;
    unique case (state_q)
      IDLE: begin
        if (cfg_valid_i && ready_q && (satTarget != tap_q)) begin
          target_d = satTarget;
          qcnt_d   = '0;
          state_d  = WAIT_QUIET;
        end
      end
      WAIT_QUIET: begin
        if (phy_busy_i) begin
          qcnt_d = '0;
        end else if (qcnt_q == QLAST) begin
          qcnt_d  = '0;
          state_d = STEP;
        end else begin
          qcnt_d = qcnt_q + QW'(1);
        end
      end
      STEP: begin
        if (phy_busy_i) begin
          qcnt_d  = '0;
          state_d = WAIT_QUIET;
        end else begin
          tap_d   = (target_q > tap_q) ? tap_q + TAP_W'(1) : tap_q - TAP_W'(1);
          scnt_d  = '0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (scnt_q == SLAST) begin
          scnt_d = '0;
          if (tap_q == target_q) begin
            state_d = IDLE;
          end else if (phy_busy_i) begin
            qcnt_d  = '0;
            state_d = WAIT_QUIET;
          end else begin
            state_d = STEP;
          end
        end else begin
          scnt_d = scnt_q + SW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so they line up with it.
  always_comb begin
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
  end

  assign delay_o     = DELAY_WORD_W'(tap_q);
  assign tap_cur_o   = tap_q;
  assign busy_o      = busy_q;
  assign cfg_ready_o = ready_q;

endmodule

// File: tb/tb_hyperbus_delay_ctrl.sv
// Scoreboard bench for hyperbus_delay_ctrl: a timing model of the tap walk
// queues expected events; a negedge monitor compares the DUT against them.
module tb_hyperbus_delay_ctrl;

  localparam int QUIET   = 4;
  localparam int SETTLE  = 2;
  localparam int MAX_TAP = 7;

  localparam int EV_START  = 0;
  localparam int EV_CHANGE = 1;
  localparam int EV_DONE   = 2;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] cfg_delay_i = '0;
  logic        cfg_valid_i = 1'b0;
  logic        phy_busy_i = 1'b0;
  logic        cfg_ready_o;
  logic [31:0] delay_o;
  logic        busy_o;
  logic [2:0]  tap_cur_o;

  logic [31:0] altCfgDelay = '0;
  logic        altCfgValid = 1'b0;
  logic        altPhyBusy = 1'b0;
  logic        altReady;
  logic [31:0] altDelay;
  logic        altBusy;
  logic [2:0]  altTap;

  hyperbus_delay_ctrl #(
    .TAP_W(3), .QUIET_CYCLES(QUIET), .SETTLE_CYCLES(SETTLE), .RESET_TAP(0)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cfg_delay_i(cfg_delay_i), .cfg_valid_i(cfg_valid_i),
    .cfg_ready_o(cfg_ready_o), .phy_busy_i(phy_busy_i), .delay_o(delay_o),
    .busy_o(busy_o), .tap_cur_o(tap_cur_o)
  );

  hyperbus_delay_ctrl #(
    .TAP_W(3), .QUIET_CYCLES(QUIET), .SETTLE_CYCLES(SETTLE), .RESET_TAP(5)
  ) dutAlt (
    .clk_i(clk_i), .rst_i(rst_i), .cfg_delay_i(altCfgDelay), .cfg_valid_i(altCfgValid),
    .cfg_ready_o(altReady), .phy_busy_i(altPhyBusy), .delay_o(altDelay),
    .busy_o(altBusy), .tap_cur_o(altTap)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int kind;
    int value;
    int cycle;
  } expItem_t;

  expItem_t expQ[$];
  int cyc = 0;
  int testsRun = 0;
  int testsFailed = 0;
  bit monEn = 1'b0;
  int modelTap = 0;
  int modelDone = 0;
  int expDelay = 0;
  bit expBusy = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Tap-walk timing model: quiet window, then one step per settle period.
  // 'extra' is the delay added by a PHY-busy pulse in relative cycle 1..QUIET+1.
  function automatic int pushTxn(input int acc, input int unsigned req, input int extra);
    int unsigned target;
    int n;
    int dir;
    int firstVis;
    expItem_t it;
    target = (req > MAX_TAP) ? MAX_TAP : req;
    n = (int'(target) > modelTap) ? int'(target) - modelTap : modelTap - int'(target);
    if (n == 0) return acc + 1;
    dir = (int'(target) > modelTap) ? 1 : -1;
    firstVis = acc + QUIET + 2 + extra;
    it.kind = EV_START; it.value = 0; it.cycle = acc + 1;
    expQ.push_back(it);
    for (int k = 1; k <= n; k++) begin
      it.kind = EV_CHANGE;
      it.value = modelTap + dir * k;
      it.cycle = firstVis + (k - 1) * (SETTLE + 1);
      expQ.push_back(it);
    end
    it.kind = EV_DONE; it.value = 0;
    it.cycle = firstVis + (n - 1) * (SETTLE + 1) + SETTLE;
    expQ.push_back(it);
    modelTap = int'(target);
    return it.cycle;
  endfunction

  logic [31:0] prevDelay = '0;
  bit prevRst = 1'b1;

  always @(negedge clk_i) begin
    if (monEn && !rst_i) begin
      while (expQ.size() > 0 && expQ[0].cycle <= cyc) begin
        if (expQ[0].cycle < cyc)
          checkOutput("missed event cycle", cyc, expQ[0].cycle);
        case (expQ[0].kind)
          EV_START:  expBusy = 1'b1;
          EV_CHANGE: expDelay = expQ[0].value;
          default:   expBusy = 1'b0;
        endcase
        void'(expQ.pop_front());
      end
      checkOutput("delay_o", delay_o, expDelay);
      checkOutput("tap_cur_o", {29'd0, tap_cur_o}, expDelay);
      checkOutput("busy_o", {31'd0, busy_o}, {31'd0, expBusy});
      checkOutput("cfg_ready_o", {31'd0, cfg_ready_o}, {31'd0, !expBusy});
      if (!prevRst)
        checkOutput("step size <= 1",
                    ((delay_o > prevDelay ? delay_o - prevDelay : prevDelay - delay_o) <= 1), 1);
    end
    prevDelay = delay_o;
    prevRst = rst_i;
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Issue one request as soon as the model says the DUT is idle; junk requests
  // may be driven while it is busy, and an optional one-cycle PHY-busy pulse.
  task automatic applyStimulus(input logic [31:0] req, input int pulseAt, input bit noise,
                               output int acc);
    while (cyc < modelDone) begin
      cfg_valid_i = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      cfg_delay_i = $urandom;
      step();
    end
    cfg_valid_i = 1'b1;
    cfg_delay_i = req;
    acc = cyc;
    modelDone = pushTxn(acc, req, pulseAt);
    step();
    cfg_valid_i = 1'b0;
    cfg_delay_i = $urandom;
    if (pulseAt > 0) begin
      while (cyc < acc + pulseAt) step();
      phy_busy_i = 1'b1;
      step();
      phy_busy_i = 1'b0;
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc;
    int d1;
    int unsigned req;
    int pulse;

    repeat (3) step();
    rst_i = 1'b0;
    expDelay = 0;
    expBusy = 1'b0;
    modelDone = cyc;
    monEn = 1'b1;
    @(negedge clk_i);
    checkOutput("alt reset delay_o", altDelay, 5);
    checkOutput("alt reset tap_cur_o", {29'd0, altTap}, 5);
    checkOutput("alt reset busy_o", {31'd0, altBusy}, 0);
    checkOutput("alt reset cfg_ready_o", {31'd0, altReady}, 1);
    step();

    applyStimulus(32'd3, 0, 1'b0, acc);
    applyStimulus(32'hFFFF_FFF0, 0, 1'b0, acc);
    applyStimulus(32'd7, 0, 1'b0, acc);
    applyStimulus(32'd4, 0, 1'b0, acc);
    applyStimulus(32'd1, 3, 1'b0, acc);
    applyStimulus(32'd5, QUIET + 1, 1'b0, acc);

    // Held request during an update is only taken in the first idle cycle.
    while (cyc < modelDone) step();
    cfg_valid_i = 1'b1;
    cfg_delay_i = 32'd2;
    acc = cyc;
    d1 = pushTxn(acc, 32'd2, 0);
    step();
    cfg_delay_i = 32'd6;
    while (cyc < d1) begin
      if (cyc == acc + 4) begin
        @(negedge clk_i);
        checkOutput("held request ready", {31'd0, cfg_ready_o}, 0);
      end
      step();
    end
    modelDone = pushTxn(d1, 32'd6, 0);
    step();
    cfg_valid_i = 1'b0;

    for (int i = 0; i < 16; i++) begin
      req = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, MAX_TAP);
      pulse = ($urandom_range(0, 2) == 0) ? $urandom_range(1, QUIET + 1) : 0;
      applyStimulus(req, pulse, 1'b1, acc);
    end

    // Reset in the middle of a 2 -> 6 walk, right after the first step.
    applyStimulus(32'd2, 0, 1'b0, acc);
    applyStimulus(32'd6, 0, 1'b0, acc);
    while (cyc < acc + QUIET + 3) step();
    rst_i = 1'b1;
    expQ.delete();
    step();
    rst_i = 1'b0;
    expDelay = 0;
    expBusy = 1'b0;
    modelTap = 0;
    modelDone = cyc;
    @(negedge clk_i);
    checkOutput("mid-update reset delay_o", delay_o, 0);
    checkOutput("mid-update reset busy_o", {31'd0, busy_o}, 0);
    checkOutput("mid-update reset cfg_ready_o", {31'd0, cfg_ready_o}, 1);

    repeat (20) step();
    checkOutput("scoreboard drained", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
